fifo_rd_prefetch: RTL
=====================

// Module: fifo_rd_prefetch
// PURPOSE
//  Read-side output stage of the async FIFO, one clock (rclk). Consumes rempty and
//  the async-read memory word (rdata = mem[raddr]). Drives rinc to the read-pointer logic.
//  Prefetches up to 2 words into a registered buffer, presented as valid/ready stream.
//  Sustains 1 word/cycle; m_valid/m_data registered, never combinational from rdata.
// PARAMETERS
//  DATA_WIDTH  8   width of memory word and m_data
//  CNT_WIDTH   8   width of saturating flush-drop counter
// PORTS
//  rclk       in   1           read-domain clock
//  rrst       in   1           synchronous, active-high reset
//  rempty     in   1           FIFO empty (registered, from read-pointer logic)
//  rdata      in   DATA_WIDTH  memory word at current raddr (combinational read)
//  rinc       out  1           pop request to read-pointer logic
//  flush      in   1           sync flush: discard buffered words
//  m_valid    out  1           output word valid
//  m_ready    in   1           downstream accepts word
//  m_data     out  DATA_WIDTH  output word (head of buffer)
//  occupancy  out  2           words held in buffer, 0..2
//  drop_cnt   out  CNT_WIDTH   words discarded by flush, saturating
// BEHAVIOUR
//  - Reset (rrst=1 at rclk edge): count=0, slot0=slot1=0, drop_cnt=0.
//    rinc forced 0 while rrst=1.
//  - State: count in {0,1,2}; slot0=head, slot1=second. m_valid=(count!=0), m_data=slot0.
//    occupancy=count.
//  - push = rinc = !rrst & !rempty & !flush & (count<2).
//    rdata is captured at the same edge rinc is high.
//  - pop = m_valid & m_ready. Neither rinc nor m_valid depends combinationally on m_ready.
//  - Update per edge (no flush):
//      cnt0 push      -> slot0<=rdata, cnt1
//      cnt1 push&pop  -> slot0<=rdata, cnt1
//      cnt1 push      -> slot1<=rdata, cnt2
//      cnt1 pop       -> cnt0
//      cnt2 pop       -> slot0<=slot1, cnt1
//      otherwise hold
//  - Latency: a word popped by rinc at edge N is on m_data from N+1 at earliest.
//  - Full buffer (count=2): rinc=0 even if !rempty; resumes the cycle after a pop.
//  - Empty FIFO: rempty=1 -> rinc=0; buffer drains normally.
//  - flush=1 at an edge:
//      rinc=0 that cycle; count<=0.
//      A pop in the same cycle completes (word delivered).
//      drop_cnt += count - pop, saturating at all-ones.
//      slot contents don't-care.
//  - Reset has priority over flush. Mid-stream reset drops buffered words; drop_cnt not incremented.
//  - m_data stable while m_valid & !m_ready (no overwrite of slot0 unless popped).
// STRUCTURE
//  - Package fifo_pkg: DATA_WIDTH default, typedef logic [DATA_WIDTH-1:0] fifo_word_t,
//    typedef enum {CNT0,CNT1,CNT2} for count encoding.
//  - Single module, no sub-modules; 2-entry buffer is inline registers plus count.
// TESTING
//  1. Reset: hold rrst 3 cycles with rempty=0
//     -> rinc=0, m_valid=0, m_data=0, occupancy=0, drop_cnt=0.
//  2. Stream: rempty=0, rdata=0x11,0x22,0x33 on successive cycles, m_ready=1
//     -> m_data 0x11,0x22,0x33 on consecutive cycles; occupancy stays 1.
//  3. Backpressure: m_ready=0, feed 0xA1,0xA2,0xA3
//     -> rinc high 2 cycles then 0, occupancy=2, m_data holds 0xA1.
//     Then m_ready=1 -> 0xA1,0xA2,0xA3 in order.
//  4. Empty: rempty=1 after one word 0x5C
//     -> rinc=0, m_valid high 1 cycle with 0x5C, then 0.
//  5. Flush: occupancy=2, m_ready=1, flush=1 for one cycle
//     -> head delivered, occupancy=0 next cycle, drop_cnt=1.
//     Repeat 300x with CNT_WIDTH=8 -> drop_cnt saturates at 0xFF.
//  6. Reset mid-stream: occupancy=2, assert rrst
//     -> next edge occupancy=0, m_valid=0, drop_cnt unchanged (0).

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types for the async FIFO read-side prefetch stage.
package fifo_pkg;

   localparam int FIFO_DATA_WIDTH = 8;
   localparam int FIFO_CNT_WIDTH  = 8;

   typedef logic [FIFO_DATA_WIDTH-1:0] fifo_word_t;

   typedef enum logic [1:0] {
      CNT0 = 2'd0,
      CNT1 = 2'd1,
      CNT2 = 2'd2
   } count_e;

endpackage

// File: rtl/fifo_rd_prefetch_if.sv
// Read-side bundle: memory/pointer handshake on one side, valid/ready stream on the other.
interface fifo_rd_prefetch_if
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int CNT_WIDTH  = FIFO_CNT_WIDTH
);
   logic                  rempty;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rinc;
   logic                  flush;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic [1:0]            occupancy;
   logic [CNT_WIDTH-1:0]  drop_cnt;

   modport master (
      input  rempty, rdata, flush, m_ready,
      output rinc, m_valid, m_data, occupancy, drop_cnt
   );

   modport slave (
      output rempty, rdata, flush, m_ready,
      input  rinc, m_valid, m_data, occupancy, drop_cnt
   );
endinterface

// File: rtl/fifo_rd_prefetch.sv
// Two-entry registered prefetch buffer between the FIFO memory read port and a stream sink.
//
// state | meaning
// CNT0  | buffer empty, m_valid low
// CNT1  | head word in slot0
// CNT2  | head in slot0, second word in slot1; no further pops from the FIFO
module fifo_rd_prefetch
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int CNT_WIDTH  = FIFO_CNT_WIDTH
) (
   input  logic                rclk,
   input  logic                rrst,
   fifo_rd_prefetch_if.master  bus
);

   count_e                count_q, count_d;
   logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
   logic [DATA_WIDTH-1:0] slot1_q, slot1_d;
   logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

   logic                  push;
   logic                  pop;
   logic [1:0]            dropped;
   logic [CNT_WIDTH:0]    drop_sum;

   // push only looks at registered state, so m_ready never reaches rinc combinationally
   assign push    = !rrst && !bus.rempty && !bus.flush && (count_q != CNT2);
   assign pop     = (count_q != CNT0) && bus.m_ready;
   assign dropped = 2'(count_q) - {1'b0, pop};
   assign drop_sum = {1'b0, drop_cnt_q} + (CNT_WIDTH+1)'(dropped);

   always_comb begin
      count_d    = count_q;
      slot0_d    = slot0_q;
      slot1_d    = slot1_q;
      drop_cnt_d = drop_cnt_q;
      if (bus.flush) begin
         count_d    = CNT0;
         drop_cnt_d = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
      end else begin
         case (count_q)
            CNT0: begin
               if (push) begin
                  slot0_d = bus.rdata;
                  count_d = CNT1;
               end
            end
            CNT1: begin
               if (push && pop) begin
                  slot0_d = bus.rdata;
               end else if (push) begin
                  slot1_d = bus.rdata;
                  count_d = CNT2;
               end else if (pop) begin
                  count_d = CNT0;
               end
            end
            CNT2: begin
               if (pop) begin
                  slot0_d = slot1_q;
                  count_d = CNT1;
               end
            end
            default: count_d = CNT0;
         endcase
      end
   end

   always_ff @(posedge rclk) begin
      if (rrst) begin
         count_q    <= CNT0;
         slot0_q    <= '0;
         slot1_q    <= '0;
         drop_cnt_q <= '0;
      end else begin
         count_q    <= count_d;
         slot0_q    <= slot0_d;
         slot1_q    <= slot1_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign bus.rinc      = push;
   assign bus.m_valid   = (count_q != CNT0);
   assign bus.m_data    = slot0_q;
   assign bus.occupancy = 2'(count_q);
   assign bus.drop_cnt  = drop_cnt_q;

endmodule
